sample_page_buffer: RTL and testbench

//  Ping-pong page buffer between the MCP3002 sampling front-end and the 24LC256 page writer.
//  - Accepts one 8-bit sample per conversion strobe.
//  - Packs samples into two 64-byte banks.
//  - Presents a full bank to the EEPROM writer and frees it again on the writer's release toggle.
//  - Sampling continues into the other bank while a page is being written.

---
 rtl/sample_page_buffer.sv | 155 +++++++++++++++
 tb/tb_sample_page_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sample_page_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_page_buffer
//  Description : Ping-pong page buffer between the ADC sampling front-end and
//                the EEPROM page writer. Samples fill one 64-byte bank while
//                the other, once full, is presented to the writer until the
//                writer toggles its release line.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_page_buffer #(
    parameter int DATA_W     = 8,
    parameter int PAGE_BYTES = 64,
    parameter int ADDR_W     = 6,
    parameter int CNT_W      = 16
) (
    input  logic              CLKsample,
    input  logic              RESET,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              page_ready,
    output logic              page_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              page_release_t,
    output logic [ADDR_W:0]   fill_count,
    output logic              overrun,
    output logic [CNT_W-1:0]  pages_written
);

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(PAGE_BYTES - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(PAGE_BYTES);

    // FILL      : filling wr_bank, nothing presented to the writer
    // FILL_PEND : filling wr_bank, the other bank is presented
    // STALL     : both banks full, incoming samples are dropped
    typedef enum logic [1:0] {
        FILL      = 2'd0,
        FILL_PEND = 2'd1,
        STALL     = 2'd2
    } state_t;

    state_t            state;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_ptr;

    logic [DATA_W-1:0] mem [0:1][0:PAGE_BYTES-1];

    logic              rel_sync1;
    logic              rel_sync2;
    logic              rel_sync3;
    logic              rel_pulse;

    logic              accept;
    logic              page_done;

    // A sample is stored whenever a bank has room; the page closes on its last byte.
    assign accept    = sample_valid && (state != STALL);
    assign page_done = accept && (wr_ptr == LAST_PTR);

    // Each edge of the writer's toggle becomes a single-cycle pulse.
    assign rel_pulse = rel_sync2 ^ rel_sync3;

    // In STALL wr_ptr has already wrapped, so report the full bank explicitly.
    assign fill_count = (state == STALL) ? FULL_COUNT : {1'b0, wr_ptr};

    // The presented bank is held steady while page_ready=1, so the writer's
    // clock domain may read it combinationally.
    assign rd_data = mem[page_sel][rd_addr];

    // Bring the writer's release toggle into the sample clock domain.
    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET) begin
            rel_sync1 <= 1'b0;
            rel_sync2 <= 1'b0;
            rel_sync3 <= 1'b0;
        end else begin
            rel_sync1 <= page_release_t;
            rel_sync2 <= rel_sync1;
            rel_sync3 <= rel_sync2;
        end
    end

    // Sample storage; contents are not cleared by reset.
    always_ff @(posedge CLKsample) begin
        if (accept) begin
            mem[wr_bank][wr_ptr] <= sample_in;
        end
    end

    // Bank hand-off state machine with its registered outputs.
    always_ff @(posedge CLKsample or negedge RESET) begin
        if (!RESET) begin
            state         <= FILL;
            wr_bank       <= 1'b0;
            wr_ptr        <= '0;
            page_ready    <= 1'b0;
            page_sel      <= 1'b0;
            overrun       <= 1'b0;
            pages_written <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case (state)
                FILL: begin
                    // A release pulse here has no pending page and is ignored.
                    if (page_done) begin
                        state         <= FILL_PEND;
                        page_ready    <= 1'b1;
                        page_sel      <= wr_bank;
                        wr_bank       <= ~wr_bank;
                        pages_written <= pages_written + 1'b1;
                    end
                end

                FILL_PEND: begin
                    if (page_done && rel_pulse) begin
                        // Writer freed its bank exactly as ours filled: swap
                        // without dropping page_ready.
                        page_sel      <= wr_bank;
                        wr_bank       <= ~wr_bank;
                        pages_written <= pages_written + 1'b1;
                    end else if (page_done) begin
                        // Completed bank must wait for the writer.
                        state <= STALL;
                    end else if (rel_pulse) begin
                        state      <= FILL;
                        page_ready <= 1'b0;
                    end
                end

                STALL: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    if (rel_pulse) begin
                        // Present the waiting bank, refill the one just released.
                        state         <= FILL_PEND;
                        page_sel      <= ~page_sel;
                        wr_bank       <= page_sel;
                        wr_ptr        <= '0;
                        pages_written <= pages_written + 1'b1;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_page_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_page_buffer
//  Description : Self-checking bench for sample_page_buffer. A table of
//                strobe/release steps with expected outputs, a queue of stored
//                samples checked against each presented page, and short
//                hand-written sequences for reset and coincident release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_page_buffer;

    logic        CLKsample = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        page_ready;
    logic        page_sel;
    logic [5:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        page_release_t = 1'b0;
    logic [6:0]  fill_count;
    logic        overrun;
    logic [15:0] pages_written;

    int tests = 0;
    int failures = 0;

    logic [7:0] next_val = '0;
    logic [7:0] exp_q[$];

    typedef struct {
        int strobes;
        int keep;
        bit chk_page;
        bit rel;
        bit ready;
        bit sel;
        int fill;
        bit ovr;
        int pages;
    } step_t;

    step_t tbl[7];

    sample_page_buffer dut (
        .CLKsample      (CLKsample),
        .RESET          (RESET),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .page_ready     (page_ready),
        .page_sel       (page_sel),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .page_release_t (page_release_t),
        .fill_count     (fill_count),
        .overrun        (overrun),
        .pages_written  (pages_written)
    );

    always #5 CLKsample = ~CLKsample;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One strobe; stored samples are queued as the expected page contents.
    task automatic strobe(input bit keep);
        @(negedge CLKsample);
        sample_in    = next_val;
        sample_valid = 1'b1;
        if (keep) exp_q.push_back(next_val);
        next_val = next_val + 8'd1;
        @(posedge CLKsample);
        #1;
        sample_valid = 1'b0;
    endtask

    // Toggle release and wait long enough for the synchronised pulse to act.
    task automatic release_page();
        @(negedge CLKsample);
        page_release_t = ~page_release_t;
        repeat (3) @(posedge CLKsample);
        #1;
    endtask

    // Read the presented bank and compare with the oldest 64 queued samples.
    task automatic check_page();
        logic [7:0] e;
        if (exp_q.size() < 64) begin
            tests++;
            failures++;
            $display("FAIL page_queue: got %0d expected 64 queued samples", exp_q.size());
        end else begin
            for (int a = 0; a < 64; a++) begin
                rd_addr = 6'(a);
                #1;
                e = exp_q.pop_front();
                chk("page_data", {24'd0, rd_data}, {24'd0, e});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLKsample);
        RESET = 1'b0;
        #1;
        chk("rst_page_ready", {31'd0, page_ready}, 32'd0);
        chk("rst_page_sel", {31'd0, page_sel}, 32'd0);
        chk("rst_fill_count", {25'd0, fill_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_pages_written", {16'd0, pages_written}, 32'd0);
        exp_q.delete();
        @(negedge CLKsample);
        RESET = 1'b1;
    endtask

    task automatic chk_outs(input string tag, input bit ready, input bit sel,
                            input int fill, input bit ovr, input int pages);
        chk({tag, "_page_ready"}, {31'd0, page_ready}, {31'd0, ready});
        chk({tag, "_page_sel"}, {31'd0, page_sel}, {31'd0, sel});
        chk({tag, "_fill_count"}, {25'd0, fill_count}, fill);
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ovr});
        chk({tag, "_pages_written"}, {16'd0, pages_written}, pages);
    endtask

    initial begin
        //           strobes keep page rel rdy sel fill ovr pages
        tbl[0] = '{  64,     64,  1,   0,  1,  0,   0,  0,  1 };  // bank 0 presented
        tbl[1] = '{  10,     10,  0,   1,  0,  0,  10,  0,  1 };  // release -> FILL
        tbl[2] = '{  54,     54,  0,   0,  1,  1,   0,  0,  2 };  // bank 1 presented
        tbl[3] = '{  64,     64,  0,   0,  1,  1,  64,  0,  2 };  // bank 0 full -> STALL
        tbl[4] = '{   1,      0,  1,   1,  1,  0,   0,  1,  3 };  // drop, release
        tbl[5] = '{   0,      0,  1,   1,  0,  0,   0,  1,  3 };  // release -> FILL
        tbl[6] = '{   5,      5,  0,   1,  0,  0,   5,  1,  3 };  // spurious release

        // Power-on reset state.
        repeat (2) @(posedge CLKsample);
        #1;
        chk_outs("reset", 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge CLKsample);
        RESET = 1'b1;

        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < tbl[i].strobes; s++) strobe(s < tbl[i].keep);
            if (tbl[i].chk_page) check_page();
            if (tbl[i].rel) release_page();
            chk_outs($sformatf("step%0d", i), tbl[i].ready, tbl[i].sel,
                     tbl[i].fill, tbl[i].ovr, tbl[i].pages);
        end

        // Release pulse lands on the same edge that completes bank 1.
        do_reset();
        for (int s = 0; s < 64; s++) strobe(1'b1);
        check_page();
        for (int s = 0; s < 63; s++) strobe(1'b1);
        @(negedge CLKsample);
        page_release_t = ~page_release_t;
        @(negedge CLKsample);
        chk("coin_ready_pre", {31'd0, page_ready}, 32'd1);
        @(negedge CLKsample);
        sample_in    = next_val;
        sample_valid = 1'b1;
        exp_q.push_back(next_val);
        next_val = next_val + 8'd1;
        chk("coin_ready_edge", {31'd0, page_ready}, 32'd1);
        @(posedge CLKsample);
        #1;
        sample_valid = 1'b0;
        chk_outs("coin", 1'b1, 1'b1, 0, 1'b0, 2);
        repeat (3) begin
            @(negedge CLKsample);
            chk("coin_ready_hold", {31'd0, page_ready}, 32'd1);
        end
        check_page();
        release_page();
        chk_outs("coin_rel", 1'b0, 1'b1, 0, 1'b0, 2);

        // Reset while bank 0 is presented and bank 1 is 30 bytes in.
        do_reset();
        for (int s = 0; s < 64; s++) strobe(1'b1);
        for (int s = 0; s < 30; s++) strobe(1'b1);
        chk_outs("pre_rst", 1'b1, 1'b0, 30, 1'b0, 1);
        do_reset();
        for (int s = 0; s < 64; s++) strobe(1'b1);
        chk_outs("post_rst", 1'b1, 1'b0, 0, 1'b0, 1);
        check_page();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
